// File: rtl/dtw_ref_streamer.sv
// Reference-memory read sequencer for the DTW PE array.
// Streams a contiguous, wrapping window of samples over valid/ready.
module dtw_ref_streamer #(
  parameter int width  = 16,
  parameter int ptrWid = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ptrWid-1:0] base_addr,
  input  logic [ptrWid:0]   ref_len,
  output logic [ptrWid-1:0] addrR,
  input  logic [width-1:0]  mem_data,
  output logic [width-1:0]  ref_data,
  output logic              ref_valid,
  input  logic              ref_ready,
  output logic              ref_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FIN
  } state_t;

  localparam logic [ptrWid:0]   LEN_ONE  = {{ptrWid{1'b0}}, 1'b1};
  localparam logic [ptrWid-1:0] ADDR_ONE = {{(ptrWid-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_nstate;
  logic [ptrWid-1:0] r_addr;
  logic [ptrWid-1:0] w_addr;
  logic [ptrWid:0]   r_len;
  logic [ptrWid:0]   w_len;
  logic [ptrWid:0]   r_issued;
  logic [ptrWid:0]   w_issued;
  logic [width-1:0]  r_data;
  logic [width-1:0]  w_data;
  logic              r_valid;
  logic              w_valid;
  logic              r_last;
  logic              w_last;
  logic              w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_addr   = r_addr;
    w_len    = r_len;
    w_issued = r_issued;
    w_data   = r_data;
    w_valid  = r_valid;
    w_last   = r_last;
    w_load   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_addr   = base_addr;
          w_len    = ref_len;
          w_issued = '0;
          w_nstate = (ref_len == '0) ? FIN : STREAM;
        end
      end
      STREAM: begin
        // A slot is free when the output is empty or being consumed.
        w_load = (!r_valid || ref_ready) && (r_issued < r_len);
        if (w_load) begin
          w_data   = mem_data;
          w_valid  = 1'b1;
          w_last   = (r_issued == r_len - LEN_ONE);
          w_addr   = r_addr + ADDR_ONE;
          w_issued = r_issued + LEN_ONE;
        end else if (r_valid && ref_ready) begin
          w_valid  = 1'b0;
          w_last   = 1'b0;
          w_nstate = FIN;
        end
      end
      FIN: begin
        w_nstate = IDLE;
      end
      default: begin
        w_nstate = IDLE;
      end
    endcase
    if (abort && (r_state != IDLE)) begin
      w_nstate = IDLE;
      w_addr   = r_addr;
      w_len    = r_len;
      w_issued = r_issued;
      w_data   = r_data;
      w_valid  = 1'b0;
      w_last   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_addr   <= w_addr;
      r_len    <= w_len;
      r_issued <= w_issued;
      r_data   <= w_data;
      r_valid  <= w_valid;
      r_last   <= w_last;
    end
  end

  assign addrR     = r_addr;
  assign ref_data  = r_data;
  assign ref_valid = r_valid;
  assign ref_last  = r_last;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);

endmodule

// File: tb/tb_dtw_ref_streamer.sv
// Randomized bench for dtw_ref_streamer against a window/queue model.
// Memory is modelled here with a combinational read port.
module tb_dtw_ref_streamer;

  localparam int W  = 16;
  localparam int PW = 15;
  localparam int D  = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] base_addr = '0;
  logic [PW:0]   ref_len = '0;
  logic [PW-1:0] addrR;
  logic [W-1:0]  mem_data;
  logic [W-1:0]  ref_data;
  logic          ref_valid;
  logic          ref_ready = 1'b0;
  logic          ref_last;
  logic          busy;
  logic          done;

  logic [W-1:0] mem [0:D-1];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[addrR];

  dtw_ref_streamer #(.width(W), .ptrWid(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .ref_len   (ref_len),
    .addrR     (addrR),
    .mem_data  (mem_data),
    .ref_data  (ref_data),
    .ref_valid (ref_valid),
    .ref_ready (ref_ready),
    .ref_last  (ref_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_mem(input int base, input int k);
    return int'(mem[(base + k) % D]);
  endfunction

  // mode 0: ready held high, mode 1: random ready.
  task automatic run_stream(input int base, input int len,
                            input int mode, input bit poke);
    int got = 0;
    int cyc = 0;
    int since = -1;
    bit fin = 1'b0;
    bit prev_stall = 1'b0;
    int prev_d = 0;
    bit rdy;
    @(negedge clk);
    base_addr = PW'(base);
    ref_len   = (PW+1)'(len);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_go", int'(busy), 1);
    while (!fin && cyc < len * 3 + 20) begin
      if (done) begin
        chk("done_cnt", got, len);
        if (len == 0) chk("done_lat0", cyc, 0);
        else chk("done_lat", since, 0);
        chk("done_novalid", int'(ref_valid), 0);
        fin = 1'b1;
      end else begin
        chk("addr_win", int'(((int'(addrR) - base + D) % D) <= len), 1);
        if (prev_stall) begin
          chk("hold_d", int'(ref_data), prev_d);
          chk("hold_v", int'(ref_valid), 1);
        end
        if (ref_valid) chk("last", int'(ref_last), int'(got == len - 1));
        rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        ref_ready = rdy;
        if (poke && cyc == 3) begin
          start = 1'b1;
          base_addr = PW'(base + 100);
        end else begin
          start = 1'b0;
        end
        if (ref_valid && rdy) begin
          if (got < len) chk("data", int'(ref_data), exp_mem(base, got));
          else chk("extra", 1, 0);
          got++;
          since = 0;
        end else if (since >= 0) begin
          since++;
        end
        prev_stall = ref_valid && !rdy;
        prev_d = int'(ref_data);
        cyc++;
        @(negedge clk);
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start = 1'b0;
    ref_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("done_once", int'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'(i + 100);
    #2;
    chk("rst_valid", int'(ref_valid), 0);
    chk("rst_addr", int'(addrR), 0);
    chk("rst_data", int'(ref_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_last", int'(ref_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_stream(10, 4, 0, 1'b0);
    run_stream(10, 4, 1, 1'b0);
    run_stream(32766, 4, 0, 1'b0);
    run_stream(32766, 4, 1, 1'b0);
    run_stream(0, 0, 0, 1'b0);
    for (int t = 0; t < 6; t++)
      run_stream(int'($urandom_range(0, D - 1)),
                 int'($urandom_range(1, 40)), 1, t[0]);

    // abort after two transfers, start in the same cycle
    @(negedge clk);
    base_addr = 15'd20;
    ref_len = 16'd6;
    start = 1'b1;
    ref_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_v0", int'(ref_valid), 0);
    @(negedge clk);
    chk("ab_d0", int'(ref_data), exp_mem(20, 0));
    @(negedge clk);
    chk("ab_d1", int'(ref_data), exp_mem(20, 1));
    @(negedge clk);
    chk("ab_d2", int'(ref_data), exp_mem(20, 2));
    abort = 1'b1;
    start = 1'b1;
    base_addr = 15'd300;
    ref_len = 16'd3;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    ref_ready = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_valid", int'(ref_valid), 0);
    chk("ab_last", int'(ref_last), 0);
    chk("ab_done", int'(done), 0);
    @(negedge clk);
    chk("ab_busy2", int'(busy), 0);
    chk("ab_done2", int'(done), 0);
    run_stream(0, 2, 0, 1'b0);

    // asynchronous reset between edges, mid-stream
    @(negedge clk);
    base_addr = 15'd50;
    ref_len = 16'd10;
    start = 1'b1;
    ref_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", int'(ref_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(ref_valid), 0);
    chk("arst_addr", int'(addrR), 0);
    chk("arst_data", int'(ref_data), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_last", int'(ref_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    chk("post_rst_valid", int'(ref_valid), 0);

    run_stream(200, 12, 1, 1'b1);
    run_stream(5, D, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dtw_ref_streamer.md
Name: dtw_ref_streamer

Overview:
- Read-side sequencer for the DTW reference memory: drives its read address and streams a contiguous window of reference samples into the DTW processing-element array.
- Uses a valid/ready handshake so the array can stall the stream.
- Sits directly downstream of the reference memory, whose read port is combinational (data equals MEM[addrR] in the same cycle), and upstream of the DTW PE chain.
- One stream per start command; the memory write port is owned elsewhere and untouched here.

Parameters:
- width, 16, reference sample width in bits (matches the memory).
- ptrWid, 15, memory address width; memory depth is 2**ptrWid.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle command; accepted only in IDLE.
- abort  input  1  cancel the current stream; return to IDLE.
- base_addr  input  ptrWid  first memory address of the window; sampled with start.
- ref_len  input  ptrWid+1  number of samples (0..2**ptrWid); sampled with start.
- addrR  output  ptrWid  read address to the reference memory.
- mem_data  input  width  memory read data (combinational from addrR).
- ref_data  output  width  registered sample to the PE array.
- ref_valid  output  1  ref_data is valid.
- ref_ready  input  1  PE array accepts ref_data when ref_valid && ref_ready.
- ref_last  output  1  qualifies the final sample of the window.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse when the stream completes normally.

Behaviour:
Reset (rst_n low, asynchronous):
- State goes to IDLE.
- addrR, ref_data, ref_len counters = 0.
- ref_valid, ref_last, busy and done = 0.

States and transitions:
- IDLE:
  - start=1: latch base_addr and ref_len, set addrR <= base_addr, issued <= 0.
  - If ref_len==0, go to FIN; otherwise go to STREAM.
  - start in any other state is ignored.
- STREAM, load condition: (!ref_valid || ref_ready) && issued < len. On a load:
  - ref_data <= mem_data, ref_valid <= 1.
  - ref_last <= (issued == len-1).
  - addrR <= addrR+1, issued <= issued+1.
- STREAM, other cases:
  - ref_valid && ref_ready with no load possible (the last sample is transferring): ref_valid <= 0, ref_last <= 0, go to FIN.
  - ref_valid && !ref_ready: ref_data, ref_last and addrR are held stable.
- FIN: done = 1 for exactly this cycle, then go to IDLE.

Timing:
- start sampled at edge E → ref_valid high after edge E+1 carrying MEM[base_addr].
- Throughput is 1 sample/cycle while ref_ready stays high.
- done rises the cycle after the last transfer.
- busy = (state != IDLE).

Address arithmetic:
- addrR is computed modulo 2**ptrWid, so the window wraps 2**ptrWid-1 → 0.
- The issued counter is ptrWid+1 bits, so the full-depth length 2**ptrWid is legal.

Boundary conditions:
- ref_len==0 → no ref_valid at all; done pulses at edge E+1.
- abort (any state except IDLE) has priority over all other actions:
  - Next state IDLE; ref_valid and ref_last cleared; no done.
  - A start in the same cycle as abort is ignored.
- abort in IDLE has no effect.
- Writes to the memory during a stream are not interlocked; the data returned is whatever the memory holds at the read cycle.
- The protocol rule (ref_data stable while ref_valid && !ref_ready) holds under every ref_ready pattern.

Test Plan:
- Memory preloaded MEM[i]=i+100. start, base_addr=10, ref_len=4, ref_ready=1 → ref_data 110,111,112,113 on consecutive cycles; ref_last only on 113; done 1 cycle after; busy low after done.
- Same stream with ref_ready toggling 1,0,0,1,0,1... → each value held stable while stalled; exactly 4 transfers; no duplicates or drops; addrR never passes 14.
- base_addr=32766, ref_len=4 (ptrWid=15) → addresses 32766, 32767, 0, 1; data MEM[32766], MEM[32767], MEM[0], MEM[1].
- ref_len=0 → ref_valid never asserted; done pulse at edge E+1. ref_len=32768 with ref_ready=1 → 32768 transfers, last flagged once, counter does not overflow.
- abort asserted after 2 of 6 transfers, with a simultaneous start → IDLE next cycle, ref_valid=0, no done. A new start, base=0, len=2, then streams MEM[0], MEM[1] correctly.
- rst_n pulled low asynchronously mid-stream (between edges) → outputs zero immediately; after release, idle until start; start during busy is ignored.
